wf_np_frame_scheduler: RTL and testbench

//  Double-buffered pixel store and write scheduler for the neopixel chain driver.
//  Two requesters share one write port into the back bank: A is the CPU/host and B is the pattern engine.
//  The driver always reads the display bank.
//  A commit from either requester swaps the banks at the next end-of-frame, so the LEDs never show a half-written frame.

---
 rtl/wf_np_frame_scheduler.sv | 148 ++++++++++++++
 tb/tb_wf_np_frame_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wf_np_frame_scheduler.sv
// Double-buffered pixel store: two requesters write the back bank, driver reads the display bank.
// Zero-latency read and grant; commits swap banks at end-of-frame, then the new display is copied back.
module wf_np_frame_scheduler #(
    parameter int NUM_PIXELS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic [7:0]  a_addr,
    input  logic [15:0] a_data,
    input  logic        a_commit,
    output logic        a_gnt,
    input  logic        b_req,
    input  logic [7:0]  b_addr,
    input  logic [15:0] b_data,
    input  logic        b_commit,
    output logic        b_gnt,
    input  logic        frame_done,
    input  logic [7:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        wr_err,
    output logic [7:0]  frame_cnt
);

    localparam int         AW   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [7:0] NP   = 8'(NUM_PIXELS);
    localparam logic [7:0] LAST = 8'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {ST_ACCEPT, ST_WAIT_EOF, ST_COPY} state_t;

    state_t      state_q, state_d;
    logic        bank_sel_q, bank_sel_d;
    logic        rr_last_q, rr_last_d;      // 1 = B was granted last
    logic        wr_err_q, wr_err_d;
    logic        commit_pend_q, commit_pend_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  copy_idx_q, copy_idx_d;

    logic [15:0] mem_q [0:1][0:NUM_PIXELS-1];
    logic          mem_we;
    logic          mem_bank;
    logic [AW-1:0] mem_idx;
    logic [15:0]   mem_wdat;

    logic        commit;
    logic        granted;
    logic [7:0]  wr_addr;
    logic [15:0] wr_dat;
    logic        in_range;

    assign commit   = a_commit | b_commit;
    assign granted  = a_gnt | b_gnt;
    assign wr_addr  = a_gnt ? a_addr : b_addr;
    assign wr_dat   = a_gnt ? a_data : b_data;
    assign in_range = wr_addr < NP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ACCEPT;
            bank_sel_q    <= 1'b0;
            rr_last_q     <= 1'b1;
            wr_err_q      <= 1'b0;
            commit_pend_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            copy_idx_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            bank_sel_q    <= bank_sel_d;
            rr_last_q     <= rr_last_d;
            wr_err_q      <= wr_err_d;
            commit_pend_q <= commit_pend_d;
            frame_cnt_q   <= frame_cnt_d;
            copy_idx_q    <= copy_idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bank_sel_d    = bank_sel_q;
        rr_last_d     = rr_last_q;
        commit_pend_d = commit_pend_q;
        frame_cnt_d   = frame_cnt_q;
        copy_idx_d    = copy_idx_q;
        wr_err_d      = granted && !in_range;
        if (a_gnt) rr_last_d = 1'b0;
        if (b_gnt) rr_last_d = 1'b1;
        case (state_q)
            ST_ACCEPT: begin
                if (commit) state_d = ST_WAIT_EOF;
            end
            ST_WAIT_EOF: begin
                if (frame_done) begin
                    bank_sel_d  = ~bank_sel_q;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    copy_idx_d  = 8'd0;
                    state_d     = ST_COPY;
                end
            end
            ST_COPY: begin
                copy_idx_d = copy_idx_q + 8'd1;
                if (commit) commit_pend_d = 1'b1;
                // A commit on the final copy cycle still counts as pending.
                if (copy_idx_q == LAST) begin
                    state_d       = (commit_pend_q || commit) ? ST_WAIT_EOF : ST_ACCEPT;
                    commit_pend_d = 1'b0;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        busy  = (state_q != ST_ACCEPT);
        if (!rst && state_q == ST_ACCEPT) begin
            if (a_req && (!b_req || rr_last_q)) a_gnt = 1'b1;
            else if (b_req)                     b_gnt = 1'b1;
        end
    end

    // Single back-bank write port shared between the copy engine and the requesters.
    always_comb begin
        mem_we   = 1'b0;
        mem_bank = ~bank_sel_q;
        mem_idx  = '0;
        mem_wdat = 16'h0000;
        if (state_q == ST_COPY) begin
            mem_we   = 1'b1;
            mem_idx  = copy_idx_q[AW-1:0];
            mem_wdat = mem_q[bank_sel_q][copy_idx_q[AW-1:0]];
        end else if (granted && in_range) begin
            mem_we   = 1'b1;
            mem_idx  = wr_addr[AW-1:0];
            mem_wdat = wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_bank][mem_idx] <= mem_wdat;
    end

    assign rd_data   = (rd_addr < NP) ? mem_q[bank_sel_q][rd_addr[AW-1:0]] : 16'h0000;
    assign wr_err    = wr_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_wf_np_frame_scheduler.sv
// Directed bench for wf_np_frame_scheduler: grants, round-robin, bank swap, copy-back, reset and counter wrap.
`timescale 1ns/100ps
module tb_wf_np_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_commit, a_gnt;
    logic [7:0]  a_addr;
    logic [15:0] a_data;
    logic        b_req, b_commit, b_gnt;
    logic [7:0]  b_addr;
    logic [15:0] b_data;
    logic        frame_done;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy, wr_err;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic [15:0] exp_back [8];

    wf_np_frame_scheduler #(.NUM_PIXELS(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_commit(a_commit), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_commit(b_commit), .b_gnt(b_gnt),
        .frame_done(frame_done), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .wr_err(wr_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // All stimulus changes happen 1ns after a rising edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input bit is_b, input logic [7:0] addr, input logic [15:0] data);
        int w = 0;
        if (is_b) begin b_req = 1'b1; b_addr = addr; b_data = data; end
        else      begin a_req = 1'b1; a_addr = addr; a_data = data; end
        #1;
        while (((is_b ? b_gnt : a_gnt) !== 1'b1) && w < 200) begin
            @(posedge clk); #2; w++;
        end
        checks++;
        if (w >= 200) begin
            errors++;
            $display("FAIL wr_timeout: gnt still 0 after %0d cycles, required 1", w);
        end else if (addr < 8) exp_back[addr[2:0]] = data;
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic pulse_commit(input bit is_b);
        if (is_b) b_commit = 1'b1; else a_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        b_commit = 1'b0;
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic do_swap();
        pulse_commit(1'b0);
        pulse_fd();
        repeat (8) tick();
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    task automatic test_reset();
        a_req = 1'b1; b_req = 1'b1;
        #12;
        checks += 5;
        if (a_gnt !== 1'b0) begin errors++; $display("FAIL rst_a_gnt: got %b, required 0", a_gnt); end
        if (b_gnt !== 1'b0) begin errors++; $display("FAIL rst_b_gnt: got %b, required 0", b_gnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (wr_err !== 1'b0) begin errors++; $display("FAIL rst_wr_err: got %b, required 0", wr_err); end
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt); end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [4:0] ea = 5'b00101;
        logic [4:0] eb = 5'b11010;
        a_req = 1'b1; a_addr = 8'd0; a_data = 16'h0AAA;
        b_req = 1'b1; b_addr = 8'd1; b_data = 16'h0BBB;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) a_req = 1'b0;
            #1;
            checks += 2;
            if (a_gnt !== ea[c]) begin errors++; $display("FAIL rr_a_gnt[%0d]: got %b, required %b", c, a_gnt, ea[c]); end
            if (b_gnt !== eb[c]) begin errors++; $display("FAIL rr_b_gnt[%0d]: got %b, required %b", c, b_gnt, eb[c]); end
            @(posedge clk); #1;
        end
        a_req = 1'b0; b_req = 1'b0;
        exp_back[0] = 16'h0AAA;
        exp_back[1] = 16'h0BBB;
    endtask

    task automatic test_single();
        a_req = 1'b1; a_addr = 8'd3; a_data = 16'h7FFF;
        #1;
        checks++;
        if (a_gnt !== 1'b1) begin errors++; $display("FAIL single_a_gnt: got %b, required 1", a_gnt); end
        @(posedge clk); #1;
        a_req = 1'b0;
        exp_back[3] = 16'h7FFF;
        pulse_commit(1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait: got %b, required 1", busy); end
        pulse_fd();
        exp_cnt = 1;
        checks++;
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL single_frame_cnt: got %0d, required 1", frame_cnt); end
        repeat (8) tick();
        rd_addr = 8'd3;
        #1;
        checks++;
        if (rd_data !== 16'h7FFF) begin errors++; $display("FAIL single_rd: got %h, required 7fff", rd_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 7; i++) wr(1'b0, 8'(i), 16'(16'h1000 + i * 16'h0111));
        // Last pixel written in the same cycle as the commit.
        a_req = 1'b1; a_addr = 8'd7; a_data = 16'h1777; a_commit = 1'b1;
        #1;
        checks++;
        if (a_gnt !== 1'b1) begin errors++; $display("FAIL fill_commit_gnt: got %b, required 1", a_gnt); end
        @(posedge clk); #1;
        a_req = 1'b0; a_commit = 1'b0;
        exp_back[7] = 16'h1777;
        pulse_fd();
        repeat (8) tick();
        exp_cnt = 2;
        checks += 2;
        if (frame_cnt !== 8'd2) begin errors++; $display("FAIL fill_frame_cnt: got %0d, required 2", frame_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL fill_busy: got %b, required 0", busy); end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 8'(i);
            #1;
            checks++;
            if (rd_data !== exp_back[i]) begin errors++; $display("FAIL fill_rd[%0d]: got %h, required %h", i, rd_data, exp_back[i]); end
            @(posedge clk); #1;
        end
        rd_addr = 8'd8;
        #1;
        checks++;
        if (rd_data !== 16'h0000) begin errors++; $display("FAIL rd_oob8: got %h, required 0000", rd_data); end
        rd_addr = 8'd255;
        #1;
        checks++;
        if (rd_data !== 16'h0000) begin errors++; $display("FAIL rd_oob255: got %h, required 0000", rd_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_addr_err();
        a_req = 1'b1; a_addr = 8'd9; a_data = 16'h7C1F;
        #1;
        checks += 2;
        if (a_gnt !== 1'b1) begin errors++; $display("FAIL err_gnt: got %b, required 1", a_gnt); end
        if (wr_err !== 1'b0) begin errors++; $display("FAIL err_early: got %b, required 0", wr_err); end
        @(posedge clk); #1;
        a_req = 1'b0;
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b, required 1", wr_err); end
        tick();
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b, required 0", wr_err); end
        do_swap();
        for (int i = 0; i < 8; i++) begin
            rd_addr = 8'(i);
            #1;
            checks++;
            if (rd_data !== exp_back[i]) begin errors++; $display("FAIL err_unchanged[%0d]: got %h, required %h", i, rd_data, exp_back[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_block();
        int bad = 0;
        // frame_done in the commit cycle must not swap.
        b_commit = 1'b1; frame_done = 1'b1;
        tick();
        b_commit = 1'b0; frame_done = 1'b0;
        checks += 2;
        if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL wait_entry_fd: frame_cnt %0d, required %0d", frame_cnt, exp_cnt); end
        if (busy !== 1'b1) begin errors++; $display("FAIL wait_entry_busy: got %b, required 1", busy); end
        a_req = 1'b1; a_addr = 8'd5; a_data = 16'h7C00;
        repeat (50) begin
            #1;
            if (!(busy === 1'b1 && a_gnt === 1'b0)) bad++;
            @(posedge clk); #1;
        end
        frame_done = 1'b1;
        #1;
        if (!(busy === 1'b1 && a_gnt === 1'b0)) bad++;
        @(posedge clk); #1;
        frame_done = 1'b0;
        exp_cnt++;
        checks += 2;
        if (bad != 0) begin errors++; $display("FAIL wait_blocked: %0d bad cycles, required 0", bad); end
        if (frame_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL wait_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
        bad = 0;
        repeat (8) begin
            #1;
            if (!(busy === 1'b1 && a_gnt === 1'b0)) bad++;
            @(posedge clk); #1;
        end
        #1;
        checks += 3;
        if (bad != 0) begin errors++; $display("FAIL copy_blocked: %0d bad cycles, required 0", bad); end
        if (a_gnt !== 1'b1) begin errors++; $display("FAIL wait_release_gnt: got %b, required 1", a_gnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_release_busy: got %b, required 0", busy); end
        @(posedge clk); #1;
        a_req = 1'b0;
        exp_back[5] = 16'h7C00;
        do_swap();
        for (int i = 0; i < 8; i++) begin
            rd_addr = 8'(i);
            #1;
            checks++;
            if (rd_data !== exp_back[i]) begin errors++; $display("FAIL coherent_rd[%0d]: got %h, required %h", i, rd_data, exp_back[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_commit_pend();
        int base = exp_cnt;
        pulse_fd();
        checks += 2;
        if (frame_cnt !== 8'(base)) begin errors++; $display("FAIL accept_fd_cnt: got %0d, required %0d", frame_cnt, base); end
        if (busy !== 1'b0) begin errors++; $display("FAIL accept_fd_busy: got %b, required 0", busy); end
        pulse_commit(1'b0);
        pulse_fd();
        repeat (2) tick();
        b_commit = 1'b1; frame_done = 1'b1;
        tick();
        b_commit = 1'b0; frame_done = 1'b0;
        repeat (5) tick();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL pend_busy: got %b, required 1", busy); end
        if (frame_cnt !== 8'(base + 1)) begin errors++; $display("FAIL pend_cnt1: got %0d, required %0d", frame_cnt, base + 1); end
        repeat (3) tick();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL pend_hold_busy: got %b, required 1", busy); end
        if (frame_cnt !== 8'(base + 1)) begin errors++; $display("FAIL pend_hold_cnt: got %0d, required %0d", frame_cnt, base + 1); end
        pulse_fd();
        checks++;
        if (frame_cnt !== 8'(base + 2)) begin errors++; $display("FAIL pend_cnt2: got %0d, required %0d", frame_cnt, base + 2); end
        repeat (8) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL pend_done_busy: got %b, required 0", busy); end
        exp_cnt = base + 2;
    endtask

    task automatic test_reset_copy();
        logic [15:0] old6;
        logic [15:0] exp6;
        do_swap();
        old6 = exp_back[6];
        wr(1'b0, 8'd6, 16'h5555);
        pulse_commit(1'b0);
        pulse_fd();
        exp_cnt++;
        // Display is bank 1 after an odd swap count; reset falls back to bank 0.
        exp6 = (exp_cnt % 2 == 1) ? old6 : 16'h5555;
        b_commit = 1'b1;
        tick();
        b_commit = 1'b0;
        repeat (2) tick();
        rst = 1'b1; a_req = 1'b1; rd_addr = 8'd6;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstc_busy: got %b, required 0", busy); end
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rstc_cnt: got %0d, required 0", frame_cnt); end
        if (a_gnt !== 1'b0) begin errors++; $display("FAIL rstc_gnt: got %b, required 0", a_gnt); end
        if (rd_data !== exp6) begin errors++; $display("FAIL rstc_bank_sel: rd %h, required %h", rd_data, exp6); end
        a_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstc_pend_dropped: busy %b, required 0", busy); end
    endtask

    task automatic test_cnt_wrap();
        repeat (255) do_swap();
        checks++;
        if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d, required 255", frame_cnt); end
        do_swap();
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d, required 0", frame_cnt); end
    endtask

    initial begin
        rst = 1'b0;
        a_req = 1'b0; a_addr = 8'd0; a_data = 16'h0000; a_commit = 1'b0;
        b_req = 1'b0; b_addr = 8'd0; b_data = 16'h0000; b_commit = 1'b0;
        frame_done = 1'b0; rd_addr = 8'd0;
        for (int i = 0; i < 8; i++) exp_back[i] = 16'h0000;
        #1 rst = 1'b1;
        test_reset();
        test_round_robin();
        test_single();
        test_fill();
        test_addr_err();
        test_wait_block();
        test_commit_pend();
        test_reset_copy();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
